// File: rtl/decade_2421_decoder.sv
// Sequence checker for a 2421 (Aiken) decade counter: decodes each qualified
// sample to BCD, tracks the 0..9 count order and carry, and tallies errors.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_UNLOCK | after reset, waiting for the first well-formed sample
// S_LOCK   | tracking; each sample must equal the expected next digit
// S_ERR    | sequence broken; next well-formed sample resynchronises
module decade_2421_decoder (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    input  logic [3:0] code,
    input  logic       z_in,
    output logic [3:0] digit,
    output logic       digit_vld,
    output logic [3:0] tens,
    output logic       locked,
    output logic       err,
    output logic [3:0] err_cnt
);

    typedef enum logic [1:0] {
        S_UNLOCK = 2'd0,
        S_LOCK   = 2'd1,
        S_ERR    = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_expected;
    logic [3:0] r_digit;
    logic [3:0] r_tens;
    logic [3:0] r_err_cnt;
    logic       r_digit_vld;
    logic       r_err;

    logic [3:0] w_dec;
    logic [3:0] w_dec_inc;
    logic       w_code_ok;
    logic       w_sample_ok;
    logic       w_accept;
    logic       w_reject;
    logic       w_tens_inc;

    always_comb begin
        w_dec     = 4'd0;
        w_code_ok = 1'b1;
        case (code)
            4'b0000: w_dec = 4'd0;
            4'b0001: w_dec = 4'd1;
            4'b0010: w_dec = 4'd2;
            4'b0011: w_dec = 4'd3;
            4'b0100: w_dec = 4'd4;
            4'b1011: w_dec = 4'd5;
            4'b1100: w_dec = 4'd6;
            4'b1101: w_dec = 4'd7;
            4'b1110: w_dec = 4'd8;
            4'b1111: w_dec = 4'd9;
            default: w_code_ok = 1'b0;
        endcase
    end

    // A sample is well-formed when the code is legal and the carry marks exactly digit 9.
    assign w_sample_ok = w_code_ok && (z_in == (w_dec == 4'd9));
    assign w_dec_inc   = (w_dec == 4'd9) ? 4'd0 : w_dec + 4'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_UNLOCK;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (x) begin
            case (r_state)
                S_UNLOCK: if (w_sample_ok) w_state_nxt = S_LOCK;
                S_LOCK:   if (!(w_sample_ok && (w_dec == r_expected))) w_state_nxt = S_ERR;
                S_ERR:    if (w_sample_ok) w_state_nxt = S_LOCK;
                default:  w_state_nxt = S_UNLOCK;
            endcase
        end
    end

    always_comb begin
        w_accept   = x && w_sample_ok && ((r_state != S_LOCK) || (w_dec == r_expected));
        w_reject   = x && !w_accept;
        w_tens_inc = w_accept && (r_state == S_LOCK) && (r_digit == 4'd9) && (w_dec == 4'd0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_expected  <= 4'd0;
            r_digit     <= 4'd0;
            r_tens      <= 4'd0;
            r_err_cnt   <= 4'd0;
            r_digit_vld <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_digit_vld <= w_accept;
            r_err       <= w_reject;
            if (w_accept) begin
                r_digit    <= w_dec;
                r_expected <= w_dec_inc;
            end
            if (w_tens_inc) begin
                r_tens <= (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
            end
            if (w_reject && (r_err_cnt != 4'hF)) begin
                r_err_cnt <= r_err_cnt + 4'd1;
            end
        end
    end

    assign digit     = r_digit;
    assign digit_vld = r_digit_vld;
    assign tens      = r_tens;
    assign locked    = (r_state == S_LOCK);
    assign err       = r_err;
    assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_decade_2421_decoder.sv
// Self-checking bench for decade_2421_decoder: directed scenarios plus random
// samples, all compared against a digit-level behavioural model.
module tb_decade_2421_decoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       x = 1'b0;
    logic [3:0] code = 4'd0;
    logic       z_in = 1'b0;
    logic [3:0] digit;
    logic       digit_vld;
    logic [3:0] tens;
    logic       locked;
    logic       err;
    logic [3:0] err_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: mode 0 = waiting, 1 = tracking, 2 = broken sequence
    int m_mode = 0;
    int m_digit = 0;
    int m_tens = 0;
    int m_err_cnt = 0;
    int m_vld = 0;
    int m_err = 0;

    logic [3:0] d2c [10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                             4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    logic [3:0] bad_codes [6] = '{4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b1010};

    decade_2421_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .code      (code),
        .z_in      (z_in),
        .digit     (digit),
        .digit_vld (digit_vld),
        .tens      (tens),
        .locked    (locked),
        .err       (err),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [3:0] c);
        for (int i = 0; i < 10; i++) begin
            if (d2c[i] == c) return i;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_digit = 0; m_tens = 0; m_err_cnt = 0; m_vld = 0; m_err = 0;
    endfunction

    function automatic void model_step(input bit xv, input logic [3:0] c, input bit z);
        int  d;
        bit  ok;
        m_vld = 0;
        m_err = 0;
        if (!xv) return;
        d  = decode(c);
        ok = (d >= 0) && (z == (d == 9));
        if (ok && (m_mode != 1 || d == (m_digit + 1) % 10)) begin
            if (m_mode == 1 && m_digit == 9 && d == 0) m_tens = (m_tens + 1) % 10;
            m_digit = d;
            m_vld   = 1;
            m_mode  = 1;
        end else begin
            m_err = 1;
            if (m_err_cnt < 15) m_err_cnt++;
            if (m_mode == 1) m_mode = 2;
        end
    endfunction

    task automatic check_outputs(input string tag);
        chk({tag, ".digit"},     int'(digit),     m_digit);
        chk({tag, ".digit_vld"}, int'(digit_vld), m_vld);
        chk({tag, ".tens"},      int'(tens),      m_tens);
        chk({tag, ".locked"},    int'(locked),    (m_mode == 1) ? 1 : 0);
        chk({tag, ".err"},       int'(err),       m_err);
        chk({tag, ".err_cnt"},   int'(err_cnt),   m_err_cnt);
    endtask

    task automatic step(input string tag, input bit xv, input logic [3:0] c, input bit z);
        @(negedge clk);
        x = xv; code = c; z_in = z;
        @(posedge clk);
        model_step(xv, c, z);
        #1 check_outputs(tag);
    endtask

    task automatic good(input string tag, input int d);
        step(tag, 1'b1, d2c[d], d == 9);
    endtask

    // Reset is asserted between clock edges so the clear must be asynchronous.
    task automatic apply_reset(input string tag);
        @(negedge clk);
        #2 reset = 1'b0;
        model_reset();
        #1 check_outputs(tag);
        @(negedge clk);
        x = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        int d;
        logic [3:0] c;
        bit z;

        #1 check_outputs("por");
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 25; i++) good("clean", i % 10);
        chk("clean_tens_end", int'(tens), 2);
        chk("clean_errcnt_end", int'(err_cnt), 0);

        apply_reset("rst_gap");
        for (int i = 0; i < 25; i++) begin
            good("gap_on", i % 10);
            step("gap_off", 1'b0, d2c[i % 10], (i % 10) == 9);
        end
        chk("gap_tens_end", int'(tens), 2);
        chk("gap_digit_end", int'(digit), 4);

        apply_reset("rst_inv");
        for (int i = 0; i < 5; i++) good("inv_pre", i);
        step("inv_0101", 1'b1, 4'b0101, 1'b0);
        chk("inv_errcnt", int'(err_cnt), 1);
        chk("inv_digit_hold", int'(digit), 4);
        step("inv_relock", 1'b1, 4'b1100, 1'b0);
        chk("inv_relock_digit", int'(digit), 6);
        chk("inv_relock_locked", int'(locked), 1);

        apply_reset("rst_skip");
        for (int i = 0; i < 4; i++) good("skip_pre", i);
        step("skip_5", 1'b1, 4'b1011, 1'b0);
        step("skip_9_noz", 1'b1, 4'b1111, 1'b0);
        chk("skip_errcnt", int'(err_cnt), 2);
        step("skip_9_z", 1'b1, 4'b1111, 1'b1);
        chk("skip_relock_digit", int'(digit), 9);
        step("skip_wrap", 1'b1, 4'b0000, 1'b0);
        chk("skip_tens", int'(tens), 1);

        apply_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 75) begin
                d = (m_mode == 1) ? (m_digit + 1) % 10 : int'($urandom_range(0, 9));
                c = d2c[d];
                z = (d == 9);
                if ($urandom_range(0, 19) == 0) z = ~z;
            end else begin
                c = 4'($urandom_range(0, 15));
                z = 1'($urandom_range(0, 1));
            end
            step("rand", 1'($urandom_range(0, 3) != 0), c, z);
        end

        apply_reset("rst_sat");
        for (int i = 0; i < 20; i++) begin
            step("sat", 1'b1, bad_codes[$urandom_range(0, 5)], 1'($urandom_range(0, 1)));
        end
        chk("sat_errcnt", int'(err_cnt), 15);
        chk("sat_err_pulse", int'(err), 1);

        apply_reset("rst_final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
